// File: rtl/cpu_pkg.sv
// Shared CPU definitions: debug command encodings, debug FSM states and
// the datapath width defaults used by the register file and debug port.
package cpu_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 2;

   typedef logic [2:0] cmd_op_t;

   localparam cmd_op_t OP_NOP     = 3'd0;
   localparam cmd_op_t OP_HALT    = 3'd1;
   localparam cmd_op_t OP_RUN     = 3'd2;
   localparam cmd_op_t OP_STEP    = 3'd3;
   localparam cmd_op_t OP_RDREG   = 3'd4;
   localparam cmd_op_t OP_WRREG   = 3'd5;
   localparam cmd_op_t OP_STATUS  = 3'd6;
   localparam cmd_op_t OP_ILLEGAL = 3'd7;

   typedef enum logic [2:0] {
      DS_RUN,
      DS_HALT_WAIT,
      DS_HALTED,
      DS_STEP_GO,
      DS_STEP_RUN,
      DS_RF_RD,
      DS_RF_WR,
      DS_RSP
   } dbg_state_e;

endpackage

// File: rtl/cpu_debug_ctrl_if.sv
// Host command/response port of the debug controller.
interface cpu_debug_ctrl_if
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF
);

   logic              cmd_valid;
   logic              cmd_ready;
   cmd_op_t           cmd_op;
   logic [ADDR_W-1:0] cmd_reg;
   logic [DATA_W-1:0] cmd_data;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_reg, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_reg, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_err
   );

endinterface

// File: rtl/dbg_step_timer.sv
// Single-step watchdog: cleared on load, counts each running cycle and
// saturates, flagging expiry on the last permitted STEP_RUN cycle.
module dbg_step_timer #(
   parameter int unsigned STEP_TIMEOUT = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic load_i,
   input  logic run_i,
   output logic expire_o
);

   localparam int unsigned CNT_W = $clog2(STEP_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STEP_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (run_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // cnt_q holds the number of completed running cycles, so this fires on
   // the STEP_TIMEOUT-th cycle and the step never exceeds the budget.
   assign expire_o = run_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Debug/run controller: gates CPU advance at instruction boundaries and
// lends the register-file port to the host while the core is halted.
module cpu_debug_ctrl
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W       = DATA_W_DEF,
   parameter int unsigned ADDR_W       = ADDR_W_DEF,
   parameter int unsigned STEP_TIMEOUT = 16,
   parameter bit          START_HALTED = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   cpu_debug_ctrl_if.slave   host,
   input  logic              cu_at_fetch,
   output logic              cpu_en,
   output logic              halted,
   output logic              dbg_rf_sel,
   output logic [ADDR_W-1:0] dbg_ra,
   output logic [ADDR_W-1:0] dbg_wa,
   output logic [DATA_W-1:0] dbg_wd,
   output logic              dbg_we,
   input  logic [DATA_W-1:0] rf_rd
);

   localparam dbg_state_e RESET_ST = START_HALTED ? DS_HALTED : DS_RUN;

   dbg_state_e        state_q, state_d;
   dbg_state_e        ret_q, ret_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_err_q, rsp_err_d;
   logic              last_err_q, last_err_d;
   logic [ADDR_W-1:0] ra_q, ra_d;
   logic [ADDR_W-1:0] wa_q, wa_d;
   logic [DATA_W-1:0] wd_q, wd_d;

   logic idle, in_run, accept;
   logic tmr_load, tmr_run, tmr_expire;

   dbg_step_timer #(
      .STEP_TIMEOUT(STEP_TIMEOUT)
   ) u_step_timer (
      .clk_i    (clk),
      .reset_i  (reset),
      .load_i   (tmr_load),
      .run_i    (tmr_run),
      .expire_o (tmr_expire)
   );

   assign idle   = (state_q == DS_RUN) || (state_q == DS_HALTED);
   assign in_run = (state_q == DS_RUN);
   assign accept = host.cmd_valid && idle;

   always_comb begin
      state_d    = state_q;
      ret_d      = ret_q;
      rsp_data_d = rsp_data_q;
      rsp_err_d  = rsp_err_q;
      last_err_d = last_err_q;
      ra_d       = ra_q;
      wa_d       = wa_q;
      wd_d       = wd_q;
      tmr_load   = 1'b0;
      tmr_run    = 1'b0;

      case (state_q)
         DS_RUN, DS_HALTED: begin
            if (accept) begin
               // Response fields are fixed here; later states only override them.
               state_d    = DS_RSP;
               ret_d      = state_q;
               rsp_data_d = '0;
               rsp_err_d  = 1'b0;
               case (host.cmd_op)
                  OP_NOP: ;
                  OP_HALT: begin
                     if (in_run) state_d = DS_HALT_WAIT;
                  end
                  OP_RUN: begin
                     ret_d      = DS_RUN;
                     last_err_d = 1'b0;
                  end
                  OP_STEP: begin
                     if (in_run) rsp_err_d = 1'b1;
                     else        state_d   = DS_STEP_GO;
                  end
                  OP_RDREG: begin
                     if (in_run) begin
                        rsp_err_d = 1'b1;
                     end else begin
                        state_d = DS_RF_RD;
                        ra_d    = host.cmd_reg;
                     end
                  end
                  OP_WRREG: begin
                     if (in_run) begin
                        rsp_err_d = 1'b1;
                     end else begin
                        state_d    = DS_RF_WR;
                        wa_d       = host.cmd_reg;
                        wd_d       = host.cmd_data;
                        rsp_data_d = host.cmd_data;
                     end
                  end
                  OP_STATUS: begin
                     rsp_data_d[1] = !in_run;
                     rsp_data_d[0] = last_err_q;
                  end
                  default: begin
                     rsp_err_d  = 1'b1;
                     last_err_d = 1'b1;
                  end
               endcase
            end
         end

         DS_HALT_WAIT: begin
            if (cu_at_fetch) begin
               state_d = DS_RSP;
               ret_d   = DS_HALTED;
            end
         end

         DS_STEP_GO: begin
            tmr_load = 1'b1;
            state_d  = DS_STEP_RUN;
         end

         DS_STEP_RUN: begin
            tmr_run = 1'b1;
            if (cu_at_fetch) begin
               state_d = DS_RSP;
               ret_d   = DS_HALTED;
            end else if (tmr_expire) begin
               state_d    = DS_RSP;
               ret_d      = DS_HALTED;
               rsp_err_d  = 1'b1;
               last_err_d = 1'b1;
            end
         end

         DS_RF_RD: begin
            rsp_data_d = rf_rd;
            state_d    = DS_RSP;
         end

         DS_RF_WR: begin
            state_d = DS_RSP;
         end

         DS_RSP: begin
            if (host.rsp_ready) state_d = ret_q;
         end

         default: begin
            state_d = RESET_ST;
            ret_d   = RESET_ST;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RESET_ST;
         ret_q      <= RESET_ST;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
         last_err_q <= 1'b0;
         ra_q       <= '0;
         wa_q       <= '0;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         ret_q      <= ret_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
         last_err_q <= last_err_d;
         ra_q       <= ra_d;
         wa_q       <= wa_d;
         wd_q       <= wd_d;
      end
   end

   always_comb begin
      cpu_en = 1'b0;
      case (state_q)
         DS_RUN, DS_STEP_GO:          cpu_en = 1'b1;
         DS_HALT_WAIT, DS_STEP_RUN:   cpu_en = !cu_at_fetch;
         default:                     cpu_en = 1'b0;
      endcase
   end

   assign halted = (state_q == DS_HALTED) || (state_q == DS_RF_RD) ||
                   (state_q == DS_RF_WR) ||
                   ((state_q == DS_RSP) && (ret_q == DS_HALTED));

   assign dbg_rf_sel = (state_q == DS_RF_RD) || (state_q == DS_RF_WR);
   // A reset landing on the write cycle must not corrupt the register file.
   assign dbg_we     = (state_q == DS_RF_WR) && !reset;
   assign dbg_ra     = ra_q;
   assign dbg_wa     = wa_q;
   assign dbg_wd     = wd_q;

   assign host.cmd_ready = idle;
   assign host.rsp_valid = (state_q == DS_RSP);
   assign host.rsp_data  = rsp_data_q;
   assign host.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl: a command vector table plus hand-driven
// halt, step and reset sequences against a small register-file model.
module tb_cpu_debug_ctrl;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic cu_at_fetch = 1'b1;

   always #5 clk = ~clk;

   cpu_debug_ctrl_if #(.DATA_W(8), .ADDR_W(2)) host ();
   cpu_debug_ctrl_if #(.DATA_W(8), .ADDR_W(2)) host2 ();

   logic       cpu_en, halted, dbg_rf_sel, dbg_we;
   logic [1:0] dbg_ra, dbg_wa;
   logic [7:0] dbg_wd, rf_rd;

   logic       cpu_en2, halted2, dbg_rf_sel2, dbg_we2;
   logic [1:0] dbg_ra2, dbg_wa2;
   logic [7:0] dbg_wd2;

   cpu_debug_ctrl #(
      .DATA_W(8), .ADDR_W(2), .STEP_TIMEOUT(16), .START_HALTED(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .host(host), .cu_at_fetch(cu_at_fetch),
      .cpu_en(cpu_en), .halted(halted), .dbg_rf_sel(dbg_rf_sel),
      .dbg_ra(dbg_ra), .dbg_wa(dbg_wa), .dbg_wd(dbg_wd), .dbg_we(dbg_we),
      .rf_rd(rf_rd)
   );

   cpu_debug_ctrl #(
      .DATA_W(8), .ADDR_W(2), .STEP_TIMEOUT(16), .START_HALTED(1'b1)
   ) dut_halted (
      .clk(clk), .reset(reset), .host(host2), .cu_at_fetch(1'b1),
      .cpu_en(cpu_en2), .halted(halted2), .dbg_rf_sel(dbg_rf_sel2),
      .dbg_ra(dbg_ra2), .dbg_wa(dbg_wa2), .dbg_wd(dbg_wd2), .dbg_we(dbg_we2),
      .rf_rd(8'h00)
   );

   logic [7:0] rf [4];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      end else if (dbg_we) begin
         rf[dbg_wa] <= dbg_wd;
      end
   end
   assign rf_rd = rf[dbg_ra];

   int         mon_sel = 0, mon_we = 0, mon_en = 0;
   logic [1:0] mon_wa = 2'd0;
   logic [7:0] mon_wd = 8'h00;
   always @(negedge clk) begin
      if (dbg_rf_sel) mon_sel <= mon_sel + 1;
      if (cpu_en)     mon_en  <= mon_en + 1;
      if (dbg_we) begin
         mon_we <= mon_we + 1;
         mon_wa <= dbg_wa;
         mon_wd <= dbg_wd;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issues one command and collects its response; lat counts clock edges
   // from acceptance to the first cycle with rsp_valid high.
   task automatic send_cmd(input logic [2:0] op, input logic [1:0] r, input logic [7:0] d,
                           output int lat, output logic err, output logic [7:0] data,
                           output logic rdy, output logic to);
      int n;
      to = 1'b0; lat = 0; err = 1'b0; data = 8'h00; rdy = 1'b0;
      host.cmd_op = op; host.cmd_reg = r; host.cmd_data = d;
      host.cmd_valid = 1'b1;
      n = 0;
      while (!host.cmd_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (!host.cmd_ready) begin
         host.cmd_valid = 1'b0;
         to = 1'b1;
         return;
      end
      @(posedge clk); #1;
      host.cmd_valid = 1'b0;
      lat = 1;
      while (!host.rsp_valid && lat < 60) begin
         @(posedge clk); #1; lat++;
      end
      if (!host.rsp_valid) begin
         to = 1'b1;
         return;
      end
      err = host.rsp_err;
      data = host.rsp_data;
      host.rsp_ready = 1'b1;
      @(posedge clk); #1;
      host.rsp_ready = 1'b0;
      rdy = host.cmd_ready;
   endtask

   typedef struct {
      logic [2:0] op;
      logic [1:0] r;
      logic [7:0] d;
      logic       cu;
      logic       err;
      logic       dchk;
      logic [7:0] data;
      int         lat;
      int         sel;
      int         we;
      logic [1:0] wa;
      logic [7:0] wd;
      int         en;    // -1 leaves cpu_en activity unchecked
   } vec_t;

   localparam int NV = 20;
   vec_t vt [NV];

   int         lat, s0, w0, e0;
   logic       err, rdy, to;
   logic [7:0] data;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      //          op          r     d      cu    err   dchk  data   lat sel we wa    wd     en
      vt[0]  = '{OP_NOP,     2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1,  0,  0, 2'd0, 8'h00, -1};
      vt[1]  = '{OP_STATUS,  2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1,  0,  0, 2'd0, 8'h00, -1};
      vt[2]  = '{OP_RDREG,   2'd1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1,  0,  0, 2'd0, 8'h00, -1};
      vt[3]  = '{OP_WRREG,   2'd1, 8'h55, 1'b1, 1'b1, 1'b0, 8'h00, 1,  0,  0, 2'd0, 8'h00, -1};
      vt[4]  = '{OP_STEP,    2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1,  0,  0, 2'd0, 8'h00, -1};
      vt[5]  = '{OP_ILLEGAL, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1,  0,  0, 2'd0, 8'h00, -1};
      vt[6]  = '{OP_STATUS,  2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1,  0,  0, 2'd0, 8'h00, -1};
      vt[7]  = '{OP_HALT,    2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2,  0,  0, 2'd0, 8'h00, -1};
      vt[8]  = '{OP_STATUS,  2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h03, 1,  0,  0, 2'd0, 8'h00,  0};
      vt[9]  = '{OP_HALT,    2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1,  0,  0, 2'd0, 8'h00,  0};
      vt[10] = '{OP_WRREG,   2'd2, 8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 2,  1,  1, 2'd2, 8'h3C,  0};
      vt[11] = '{OP_WRREG,   2'd1, 8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 2,  1,  1, 2'd1, 8'hA5,  0};
      vt[12] = '{OP_RDREG,   2'd2, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 2,  1,  0, 2'd0, 8'h00,  0};
      vt[13] = '{OP_RDREG,   2'd1, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 2,  1,  0, 2'd0, 8'h00,  0};
      vt[14] = '{OP_RDREG,   2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 2,  1,  0, 2'd0, 8'h00,  0};
      vt[15] = '{OP_STEP,    2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 18, 0,  0, 2'd0, 8'h00, 17};
      vt[16] = '{OP_STATUS,  2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h03, 1,  0,  0, 2'd0, 8'h00,  0};
      vt[17] = '{OP_RUN,     2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1,  0,  0, 2'd0, 8'h00, -1};
      vt[18] = '{OP_STATUS,  2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1,  0,  0, 2'd0, 8'h00, -1};
      vt[19] = '{OP_RDREG,   2'd3, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1,  0,  0, 2'd0, 8'h00, -1};

      host.cmd_valid = 1'b0; host.cmd_op = OP_NOP; host.cmd_reg = 2'd0;
      host.cmd_data = 8'h00; host.rsp_ready = 1'b0;
      host2.cmd_valid = 1'b0; host2.cmd_op = OP_NOP; host2.cmd_reg = 2'd0;
      host2.cmd_data = 8'h00; host2.rsp_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("rst cpu_en", cpu_en, 1);
      chk("rst halted", halted, 0);
      chk("rst cmd_ready", host.cmd_ready, 1);
      chk("rst rsp_valid", host.rsp_valid, 0);
      chk("rst rsp_err", host.rsp_err, 0);
      chk("rst rsp_data", host.rsp_data, 0);
      chk("rst rf_sel", dbg_rf_sel, 0);
      chk("rst dbg_we", dbg_we, 0);
      chk("rst dbg_addr", {dbg_ra, dbg_wa, dbg_wd}, 0);
      chk("rst2 halted", halted2, 1);
      chk("rst2 cpu_en", cpu_en2, 0);
      chk("rst2 cmd_ready", host2.cmd_ready, 1);
      chk("rst2 rsp", {host2.rsp_valid, host2.rsp_err, host2.rsp_data}, 0);
      chk("rst2 dbg", {dbg_rf_sel2, dbg_we2, dbg_ra2, dbg_wa2, dbg_wd2}, 0);

      for (int i = 0; i < NV; i++) begin
         cu_at_fetch = vt[i].cu;
         s0 = mon_sel; w0 = mon_we; e0 = mon_en;
         send_cmd(vt[i].op, vt[i].r, vt[i].d, lat, err, data, rdy, to);
         chk($sformatf("v%0d timeout", i), to, 0);
         chk($sformatf("v%0d latency", i), lat, vt[i].lat);
         chk($sformatf("v%0d rsp_err", i), err, vt[i].err);
         if (vt[i].dchk) chk($sformatf("v%0d rsp_data", i), data, vt[i].data);
         chk($sformatf("v%0d ready_after", i), rdy, 1);
         chk($sformatf("v%0d rf_sel_cycles", i), mon_sel - s0, vt[i].sel);
         chk($sformatf("v%0d we_pulses", i), mon_we - w0, vt[i].we);
         if (vt[i].we > 0) begin
            chk($sformatf("v%0d dbg_wa", i), mon_wa, vt[i].wa);
            chk($sformatf("v%0d dbg_wd", i), mon_wd, vt[i].wd);
         end
         if (vt[i].en >= 0) chk($sformatf("v%0d cpu_en_cycles", i), mon_en - e0, vt[i].en);
      end

      // HALT while the CU is mid-instruction for three cycles
      cu_at_fetch = 1'b0;
      #1;
      chk("halt pre ready", host.cmd_ready, 1);
      host.cmd_op = OP_HALT; host.cmd_valid = 1'b1;
      @(posedge clk); #1;
      host.cmd_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("halt wait%0d cpu_en", k), cpu_en, 1);
         chk($sformatf("halt wait%0d rsp_valid", k), host.rsp_valid, 0);
         @(posedge clk); #1;
      end
      cu_at_fetch = 1'b1;
      #1;
      chk("halt fetch cpu_en", cpu_en, 0);
      @(posedge clk); #1;
      chk("halt rsp_valid", host.rsp_valid, 1);
      chk("halt rsp_err", host.rsp_err, 0);
      chk("halt halted", halted, 1);
      host.rsp_ready = 1'b1;
      @(posedge clk); #1;
      host.rsp_ready = 1'b0;

      // STEP where the instruction returns to FETCH after four cycles
      e0 = 0;
      host.cmd_op = OP_STEP; host.cmd_valid = 1'b1;
      @(posedge clk); #1;
      host.cmd_valid = 1'b0;
      if (cpu_en) e0++;
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         cu_at_fetch = 1'b0;
         #1;
         if (cpu_en) e0++;
         @(posedge clk); #1;
      end
      cu_at_fetch = 1'b1;
      #1;
      if (cpu_en) e0++;
      @(posedge clk); #1;
      chk("step cpu_en_cycles", e0, 5);
      chk("step rsp_valid", host.rsp_valid, 1);
      chk("step rsp_err", host.rsp_err, 0);
      chk("step halted", halted, 1);
      host.rsp_ready = 1'b1;
      @(posedge clk); #1;
      host.rsp_ready = 1'b0;
      chk("step cpu_en after", cpu_en, 0);

      // Reset landing on the register write cycle
      host.cmd_op = OP_WRREG; host.cmd_reg = 2'd3; host.cmd_data = 8'h77;
      host.cmd_valid = 1'b1;
      @(posedge clk); #1;
      host.cmd_valid = 1'b0;
      chk("wr rf_sel", dbg_rf_sel, 1);
      reset = 1'b1;
      #1;
      chk("wr reset dbg_we", dbg_we, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      chk("wr reset state", {cpu_en, halted, host.rsp_valid}, 3'b100);

      // Response held without rsp_ready, then aborted by reset
      host.cmd_op = OP_NOP; host.cmd_valid = 1'b1;
      @(posedge clk); #1;
      host.cmd_valid = 1'b0;
      chk("hold rsp_valid", host.rsp_valid, 1);
      @(posedge clk); #1;
      chk("hold rsp_valid2", host.rsp_valid, 1);
      chk("hold rsp_data", host.rsp_data, 0);
      chk("hold cmd_ready", host.cmd_ready, 0);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("abort rsp_valid", host.rsp_valid, 0);
      chk("abort cpu_en", cpu_en, 1);
      chk("abort rf3 untouched", rf[3], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
